// File: rtl/wb_interconnect_nxm_pkg.sv
// wb_interconnect_nxm_pkg: shared widths, arbiter state encoding and address decode helper
package wb_interconnect_nxm_pkg;
  localparam int ADR_MAX = 64;
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic adr_match(input logic [ADR_MAX-1:0] adr, input logic [ADR_MAX-1:0] mask,
                                     input logic [ADR_MAX-1:0] base);
    return (adr & mask) == base;
  endfunction
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: per-target round-robin grant FSM holding the owner until released
module wb_rr_arbiter
  import wb_interconnect_nxm_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          release_i,
  output logic [IW-1:0] owner_o,
  output logic          valid_o
);
  arb_state_e    state_q;
  logic [IW-1:0] owner_q, ptr_q, pick;
  logic [N-1:0]  rot;
  // first requester at or after the round-robin pointer
  always_comb begin
    rot  = N'({req_i, req_i} >> ptr_q);
    pick = ptr_q;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) pick = IW'((int'(ptr_q) + i) % N);
  end
  // grant on idle, hold until released, then advance the pointer past the owner
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (|req_i) begin
        owner_q <= pick;
        state_q <= ARB_BUSY;
      end
    end else if (release_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IW'((int'(owner_q) + 1) % N);
    end
  end
  assign valid_o = state_q == ARB_BUSY;
  assign owner_o = owner_q;
endmodule

// File: rtl/wb_interconnect_nxm.sv
// wb_interconnect_nxm: N-initiator x M-target Wishbone classic crossbar with arbitration, error responder and timeout
module wb_interconnect_nxm
  import wb_interconnect_nxm_pkg::*;
#(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int N_INITIATORS = 2,
  parameter int N_TARGETS = 2,
  parameter logic [N_TARGETS*ADR_WIDTH-1:0] T_ADR_MASK = {N_TARGETS{32'hFF00_0000}},
  parameter logic [N_TARGETS*ADR_WIDTH-1:0] T_ADR = {32'h1000_0000, 32'h0000_0000},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_INITIATORS*ADR_WIDTH-1:0]   t_adr,
  input  logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_w,
  output logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_r,
  input  logic [N_INITIATORS-1:0]             t_cyc,
  input  logic [N_INITIATORS-1:0]             t_stb,
  input  logic [N_INITIATORS*DAT_WIDTH/8-1:0] t_sel,
  input  logic [N_INITIATORS-1:0]             t_we,
  output logic [N_INITIATORS-1:0]             t_ack,
  output logic [N_INITIATORS-1:0]             t_err,
  output logic [N_TARGETS*ADR_WIDTH-1:0]      i_adr,
  output logic [N_TARGETS*DAT_WIDTH-1:0]      i_dat_w,
  input  logic [N_TARGETS*DAT_WIDTH-1:0]      i_dat_r,
  output logic [N_TARGETS-1:0]                i_cyc,
  output logic [N_TARGETS-1:0]                i_stb,
  output logic [N_TARGETS*DAT_WIDTH/8-1:0]    i_sel,
  output logic [N_TARGETS-1:0]                i_we,
  input  logic [N_TARGETS-1:0]                i_ack,
  input  logic [N_TARGETS-1:0]                i_err
);
  localparam int INI_IDX_W = idx_w(N_INITIATORS);
  localparam int TGT_IDX_W = idx_w(N_TARGETS);
  localparam int SEL_W = DAT_WIDTH / 8;
  localparam int CNT_W = idx_w(TIMEOUT_CYCLES + 1);
  logic [N_INITIATORS-1:0] hit, gnt_any, tgt_err, run, fire, err_resp_d, err_resp_q, tmo_q;
  logic [TGT_IDX_W-1:0]    dsel [N_INITIATORS];
  logic [CNT_W-1:0]        cnt_d [N_INITIATORS];
  logic [CNT_W-1:0]        cnt_q [N_INITIATORS];
  logic [N_INITIATORS-1:0] req [N_TARGETS];
  logic [INI_IDX_W-1:0]    owner [N_TARGETS];
  logic [N_TARGETS-1:0]    valid, rel;
  // address decode per initiator; iterating downwards lets the lowest matching target win
  always_comb begin
    for (int j = 0; j < N_INITIATORS; j++) begin
      hit[j]  = 1'b0;
      dsel[j] = '0;
      for (int k = N_TARGETS - 1; k >= 0; k--)
        if (adr_match(ADR_MAX'(t_adr[j*ADR_WIDTH +: ADR_WIDTH]), ADR_MAX'(T_ADR_MASK[k*ADR_WIDTH +: ADR_WIDTH]),
                      ADR_MAX'(T_ADR[k*ADR_WIDTH +: ADR_WIDTH]))) begin
          hit[j]  = 1'b1;
          dsel[j] = TGT_IDX_W'(k);
        end
    end
  end
  // request matrix: initiator j strobing an address that decodes to target k
  always_comb begin
    for (int k = 0; k < N_TARGETS; k++)
      for (int j = 0; j < N_INITIATORS; j++)
        req[k][j] = t_cyc[j] & t_stb[j] & hit[j] & (dsel[j] == TGT_IDX_W'(k));
  end
  for (genvar k = 0; k < N_TARGETS; k++) begin : g_arb
    wb_rr_arbiter #(.N(N_INITIATORS), .IW(INI_IDX_W)) u_arb (
      .clock    (clock),
      .reset    (reset),
      .req_i    (req[k]),
      .release_i(rel[k]),
      .owner_o  (owner[k]),
      .valid_o  (valid[k])
    );
  end
  // forward the owner's bus signals to each granted target; idle targets see zeros
  always_comb begin
    i_cyc   = '0;
    i_stb   = '0;
    i_we    = '0;
    i_adr   = '0;
    i_dat_w = '0;
    i_sel   = '0;
    for (int k = 0; k < N_TARGETS; k++)
      if (valid[k]) begin
        i_cyc[k] = t_cyc[owner[k]];
        i_stb[k] = t_stb[owner[k]];
        i_we[k]  = t_we[owner[k]];
        i_adr[k*ADR_WIDTH +: ADR_WIDTH]   = t_adr[int'(owner[k])*ADR_WIDTH +: ADR_WIDTH];
        i_dat_w[k*DAT_WIDTH +: DAT_WIDTH] = t_dat_w[int'(owner[k])*DAT_WIDTH +: DAT_WIDTH];
        i_sel[k*SEL_W +: SEL_W]           = t_sel[int'(owner[k])*SEL_W +: SEL_W];
      end
  end
  // return path from the granted target plus locally generated errors
  always_comb begin
    gnt_any = '0;
    t_ack   = '0;
    tgt_err = '0;
    t_dat_r = '0;
    for (int j = 0; j < N_INITIATORS; j++)
      for (int k = 0; k < N_TARGETS; k++)
        if (valid[k] && owner[k] == INI_IDX_W'(j)) begin
          gnt_any[j] = 1'b1;
          t_ack[j]   = t_ack[j] | i_ack[k];
          tgt_err[j] = tgt_err[j] | i_err[k];
          t_dat_r[j*DAT_WIDTH +: DAT_WIDTH] = t_dat_r[j*DAT_WIDTH +: DAT_WIDTH] | i_dat_r[k*DAT_WIDTH +: DAT_WIDTH];
        end
    t_err = tgt_err | err_resp_q | tmo_q;
  end
  // stall counting, timeout abort and decode-error pulse generation per initiator
  always_comb begin
    for (int j = 0; j < N_INITIATORS; j++) begin
      run[j]        = (TIMEOUT_CYCLES != 0) & gnt_any[j] & t_stb[j] & ~t_ack[j] & ~tgt_err[j];
      fire[j]       = run[j] & (cnt_q[j] == CNT_W'(TIMEOUT_CYCLES - 1));
      cnt_d[j]      = (run[j] & ~fire[j]) ? cnt_q[j] + CNT_W'(1) : '0;
      err_resp_d[j] = t_cyc[j] & t_stb[j] & ~hit[j] & ~err_resp_q[j];
    end
  end
  // a grant ends when its owner drops cyc or its stall timer expires
  always_comb begin
    for (int k = 0; k < N_TARGETS; k++) rel[k] = valid[k] & (~t_cyc[owner[k]] | fire[owner[k]]);
  end
  // registered error pulses and stall counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_resp_q <= '0;
      tmo_q      <= '0;
      for (int j = 0; j < N_INITIATORS; j++) cnt_q[j] <= '0;
    end else begin
      err_resp_q <= err_resp_d;
      tmo_q      <= fire;
      for (int j = 0; j < N_INITIATORS; j++) cnt_q[j] <= cnt_d[j];
    end
  end
`ifndef SYNTHESIS
  for (genvar k = 0; k < N_TARGETS; k++) begin : g_chk
    a_owner_stays : assert property (@(posedge clock) disable iff (reset)
      (valid[k] && t_cyc[owner[k]] && t_stb[owner[k]]) |-> (hit[owner[k]] && dsel[owner[k]] == TGT_IDX_W'(k)));
  end
`endif
endmodule

// File: tb/tb_wb_interconnect_nxm.sv
// tb_wb_interconnect_nxm: directed checks of arbitration, return path, error responder and timeout
module tb_wb_interconnect_nxm;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] t_adr = '0, t_dat_w = '0, i_dat_r = '0;
  logic [63:0] t_dat_r, i_adr, i_dat_w;
  logic [1:0]  t_cyc = '0, t_stb = '0, t_we = '0, i_ack = '0, i_err = '0;
  logic [1:0]  t_ack, t_err, i_cyc, i_stb, i_we;
  logic [7:0]  t_sel = '0;
  logic [7:0]  i_sel;
  int total = 0, bad = 0;

  wb_interconnect_nxm #(.TIMEOUT_CYCLES(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .t_adr  (t_adr),
    .t_dat_w(t_dat_w),
    .t_dat_r(t_dat_r),
    .t_cyc  (t_cyc),
    .t_stb  (t_stb),
    .t_sel  (t_sel),
    .t_we   (t_we),
    .t_ack  (t_ack),
    .t_err  (t_err),
    .i_adr  (i_adr),
    .i_dat_w(i_dat_w),
    .i_dat_r(i_dat_r),
    .i_cyc  (i_cyc),
    .i_stb  (i_stb),
    .i_sel  (i_sel),
    .i_we   (i_we),
    .i_ack  (i_ack),
    .i_err  (i_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int j, input logic c, input logic s, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] sl);
    t_cyc[j] = c;
    t_stb[j] = s;
    t_we[j]  = w;
    t_adr[j*32 +: 32]  = a;
    t_dat_w[j*32 +: 32] = d;
    t_sel[j*4 +: 4]    = sl;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ack", 64'(t_ack), 64'(0));
    chk("rst_err", 64'(t_err), 64'(0));
    chk("rst_dat_r", t_dat_r, 64'(0));
    chk("rst_cyc", 64'(i_cyc), 64'(0));
    chk("rst_adr", i_adr, 64'(0));
    reset = 1'b0;
    // single read through target 1
    drive(0, 1, 1, 32'h1000_0004, 0, 0, 4'hF);
    chk("rd_nogrant", 64'(i_stb), 64'(0));
    tick;
    chk("rd_stb", 64'(i_stb), 64'(2'b10));
    chk("rd_adr", 64'(i_adr[63:32]), 64'(32'h1000_0004));
    tick;
    tick;
    i_dat_r[63:32] = 32'hDEAD_BEEF;
    i_ack[1] = 1'b1;
    #1;
    chk("rd_ack", 64'(t_ack), 64'(2'b01));
    chk("rd_data", 64'(t_dat_r[31:0]), 64'(32'hDEAD_BEEF));
    chk("rd_data_other", 64'(t_dat_r[63:32]), 64'(0));
    tick;
    i_ack = '0;
    i_dat_r = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rd_drop_cyc", 64'(i_cyc), 64'(0));
    tick;
    // contention on target 0
    drive(0, 1, 1, 32'h10, 1, 32'hA5A5_0001, 4'h3);
    drive(1, 1, 1, 32'h20, 0, 0, 4'hF);
    tick;
    chk("rr_first_adr", 64'(i_adr[31:0]), 64'(32'h10));
    chk("rr_first_cyc", 64'(i_cyc), 64'(2'b01));
    chk("wr_we", 64'(i_we), 64'(2'b01));
    chk("wr_dat", 64'(i_dat_w[31:0]), 64'(32'hA5A5_0001));
    chk("wr_sel", 64'(i_sel[3:0]), 64'(4'h3));
    i_ack[0] = 1'b1;
    #1;
    chk("wr_ack", 64'(t_ack), 64'(2'b01));
    tick;
    i_ack = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("rr_idle_gap", 64'(i_cyc), 64'(0));
    tick;
    chk("rr_second_adr", 64'(i_adr[31:0]), 64'(32'h20));
    i_err[0] = 1'b1;
    #1;
    chk("tgt_err", 64'(t_err), 64'(2'b10));
    chk("tgt_err_noack", 64'(t_ack), 64'(0));
    tick;
    i_err = '0;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick;
    // cycle lock across a strobe-low gap
    drive(0, 1, 1, 32'h30, 0, 0, 4'hF);
    tick;
    drive(0, 1, 0, 32'h30, 0, 0, 4'hF);
    drive(1, 1, 1, 32'h40, 0, 0, 4'hF);
    for (int n = 0; n < 5; n++) begin
      tick;
      chk("lock_adr", 64'(i_adr[31:0]), 64'(32'h30));
    end
    chk("lock_stb_low", 64'(i_stb), 64'(0));
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("lock_gap", 64'(i_cyc), 64'(0));
    tick;
    chk("lock_next_adr", 64'(i_adr[31:0]), 64'(32'h40));
    chk("lock_next_stb", 64'(i_stb), 64'(2'b01));
    drive(1, 0, 0, 0, 0, 0, 0);
    tick;
    // unmapped address
    drive(0, 1, 1, 32'h5000_0000, 0, 0, 4'hF);
    chk("unm_err_early", 64'(t_err), 64'(0));
    tick;
    chk("unm_err", 64'(t_err), 64'(2'b01));
    chk("unm_ack", 64'(t_ack), 64'(0));
    chk("unm_cyc", 64'(i_cyc), 64'(0));
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("unm_err_once", 64'(t_err), 64'(0));
    // timeout on target 1 with a second requester waiting
    drive(0, 1, 1, 32'h1000_0000, 0, 0, 4'hF);
    tick;
    chk("tmo_grant", 64'(i_cyc), 64'(2'b10));
    drive(1, 1, 1, 32'h1000_0100, 0, 0, 4'hF);
    repeat (7) tick;
    chk("tmo_not_yet", 64'(t_err), 64'(0));
    chk("tmo_still_held", 64'(i_adr[63:32]), 64'(32'h1000_0000));
    tick;
    chk("tmo_err", 64'(t_err), 64'(2'b01));
    chk("tmo_release", 64'(i_cyc), 64'(0));
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("tmo_err_once", 64'(t_err), 64'(0));
    chk("tmo_next_adr", 64'(i_adr[63:32]), 64'(32'h1000_0100));
    chk("tmo_next_cyc", 64'(i_cyc), 64'(2'b10));
    drive(1, 0, 0, 0, 0, 0, 0);
    tick;
    // ack on the cycle the timeout would fire
    drive(0, 1, 1, 32'h50, 0, 0, 4'hF);
    tick;
    repeat (7) tick;
    i_ack[0] = 1'b1;
    #1;
    chk("race_ack", 64'(t_ack), 64'(2'b01));
    tick;
    i_ack = '0;
    #1;
    chk("race_no_tmo", 64'(t_err), 64'(0));
    chk("race_held", 64'(i_cyc), 64'(2'b01));
    drive(0, 0, 0, 0, 0, 0, 0);
    tick;
    // reset in the middle of a transfer
    drive(1, 1, 1, 32'h60, 0, 0, 4'hF);
    tick;
    chk("rst_mid_grant", 64'(i_adr[31:0]), 64'(32'h60));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_cyc", 64'(i_cyc), 64'(0));
    chk("rst_mid_stb", 64'(i_stb), 64'(0));
    drive(0, 1, 1, 32'h70, 0, 0, 4'hF);
    tick;
    reset = 1'b0;
    tick;
    chk("rst_ptr_zero", 64'(i_adr[31:0]), 64'(32'h70));
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_interconnect_nxm.md
Name: wb_interconnect_nxm

Overview:
- Parametrised N-initiator × M-target Wishbone classic interconnect.
- Replaces the purely combinational single-initiator decoder: adds per-target registered round-robin arbitration, cycle locking, an internal decode-error responder and a per-initiator bus timeout.
- Sits between CPU/DMA masters and peripheral/memory slaves at the SoC fabric level.

Parameters:
- ADR_WIDTH, 32, address width.
- DAT_WIDTH, 32, data width; must be a multiple of 8.
- N_INITIATORS, 2, number of masters attached to the interconnect.
- N_TARGETS, 2, number of slaves.
- T_ADR_MASK, {N_TARGETS{32'hFF00_0000}}, packed per-target address masks; entry 0 in the LSBs.
- T_ADR, {32'h1000_0000, 32'h0000_0000}, packed per-target base addresses; entry 0 in the LSBs.
- TIMEOUT_CYCLES, 256, stall cycles before a forced error response; 0 disables the timeout.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- t_adr  in  N_INITIATORS*ADR_WIDTH  initiator addresses
- t_dat_w  in  N_INITIATORS*DAT_WIDTH  initiator write data
- t_dat_r  out  N_INITIATORS*DAT_WIDTH  read data returned to each initiator
- t_cyc  in  N_INITIATORS  cycle
- t_stb  in  N_INITIATORS  strobe
- t_sel  in  N_INITIATORS*DAT_WIDTH/8  byte selects
- t_we  in  N_INITIATORS  write enable
- t_ack  out  N_INITIATORS  acknowledge
- t_err  out  N_INITIATORS  error
- i_adr  out  N_TARGETS*ADR_WIDTH  address to each target
- i_dat_w  out  N_TARGETS*DAT_WIDTH  write data to each target
- i_dat_r  in  N_TARGETS*DAT_WIDTH  target read data
- i_cyc  out  N_TARGETS  cycle to each target
- i_stb  out  N_TARGETS  strobe to each target
- i_sel  out  N_TARGETS*DAT_WIDTH/8  byte selects to each target
- i_we  out  N_TARGETS  write enable to each target
- i_ack  in  N_TARGETS  target acknowledge
- i_err  in  N_TARGETS  target error

Behaviour:
- Reset is asynchronous and active-high on the reset port; the clock is clock.
- Decode: per initiator, combinational. Target k matches when (t_adr & MASK[k]) == ADR[k]. The lowest matching index wins. No match means the request goes to the error responder.
- Request: initiator j requests target k when t_cyc[j] & t_stb[j] and the decode selects k.
- Per-target arbiter FSM, IDLE/BUSY:
  - IDLE: if any requests are present, at the clock edge grant the first requester at or after rr_ptr (wrapping at N_INITIATORS), store the owner, go to BUSY. Grant latency is 1 cycle.
  - BUSY: i_cyc, i_stb, i_adr, i_dat_w, i_sel and i_we follow the owner combinationally.
  - BUSY → IDLE when t_cyc[owner] = 0, or on timeout abort. On that edge rr_ptr = owner+1 mod N_INITIATORS.
  - One idle cycle separates consecutive owners.
  - The grant is locked for the whole t_cyc, including stb-low gaps.
  - If the owner changes address to a different target while holding the grant, behaviour is unsupported and flagged by a simulation-only assertion.
- Return path, combinational:
  - t_ack[j] = i_ack[k] & granted(j,k).
  - t_err[j] = (i_err[k] & granted) | err_resp[j] | tmo_err[j].
  - t_dat_r[j] = i_dat_r[k] when granted, else 0.
- Error responder, per initiator:
  - err_resp[j] is registered: next = t_cyc & t_stb & nomatch & ~err_resp.
  - This gives a one-cycle error pulse one cycle after strobe, at most every other cycle while stb is held.
  - t_ack stays 0.
- Timeout, per initiator:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) increments while granted with t_stb high and no ack/err.
  - It clears on ack, err or stb low.
  - At count == TIMEOUT_CYCLES-1 with no ack that cycle: tmo_err pulses for 1 cycle at the next edge, the target grant is released on the same edge, and the counter clears.
- Simultaneous events:
  - An ack arriving in the same cycle the timeout fires wins: no timeout.
  - Requests from all initiators in the same cycle are granted strictly in round-robin order.
- Reset values: all FSMs IDLE, rr_ptr = 0, counters 0, err_resp 0, tmo_err 0.
  - Hence i_cyc, i_stb, t_ack, t_err = 0 and t_dat_r = 0.
  - i_adr, i_dat_w, i_sel and i_we are 0 when no grant is held.
- Reset asserted mid-transfer drops i_cyc and i_stb immediately (combinational from state).

Decomposition:
- Shared package/include holds:
  - width constants INI_IDX_W = $clog2(N_INITIATORS) (min 1) and TGT_IDX_W;
  - the FSM state encoding (IDLE = 0, BUSY = 1);
  - a decode function shared with other fabric blocks.
- One sub-module, wb_rr_arbiter: request vector in, owner index, grant valid and release in; contains the FSM and rr_ptr. It is instantiated N_TARGETS times.

Test Plan:
- Single-initiator read: j0 reads 0x1000_0004; target1 acks 2 cycles after i_stb with data 0xDEAD_BEEF → i_stb[1] rises 1 cycle after t_stb[0], t_dat_r[0] = 0xDEADBEEF with t_ack[0] = 1.
- Contention: j0 and j1 both request target0 in the same cycle with rr_ptr = 0 → j0 granted first. After j0 drops cyc there is 1 idle cycle, then j1 is granted; rr_ptr = 1 afterwards.
- Cycle lock: j0 holds cyc with stb low for 5 cycles while j1 requests → j1 is not granted until j0 deasserts cyc.
- Unmapped access: t_adr = 0x5000_0000 → t_err[0] = 1 for exactly 1 cycle, 1 cycle after strobe. No i_cyc is asserted and t_ack = 0.
- Timeout: TIMEOUT_CYCLES = 8, target never acks → t_err pulses 8 cycles after grant, i_cyc drops on the same edge, and the next requester is granted.
- Reset mid-transfer: assert reset while BUSY → i_cyc = 0 immediately; after release all grants IDLE and rr_ptr = 0.
